// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Brief    : Loads a program image into CPU RAM, then clears and gates the CPU
//            to run, single-step or stop it (halt, cycle budget, self-jump).
// Revision : 1.0  initial release
// ============================================================================
module cpu_run_controller #(
    parameter int DATA_W = 11,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8,
    parameter int CYC_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              run_start,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              cpu_reset,
    output logic              pc_enable,
    output logic              busy,
    output logic              loaded,
    output logic              done,
    output logic [1:0]        stop_cause,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_clear = 3'd2;
    localparam logic [2:0] c_st_run   = 3'd3;
    localparam logic [2:0] c_st_step  = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_accept;
    logic [1:0]        w_cause;
    logic [CYC_W:0]    w_count_inc;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_last_pc;
    logic              r_in_ready;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_waddr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic              r_cpu_reset;
    logic              r_pc_enable;
    logic              r_busy;
    logic              r_loaded;
    logic              r_done;
    logic [1:0]        r_stop_cause;
    logic [CYC_W-1:0]  r_cycle_count;

    assign w_count_inc = {1'b0, r_cycle_count} + {{CYC_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cause     = 2'd0;
        case (r_state)
            c_st_idle: begin
                if (load_start)                 w_state_nxt = c_st_load;
                else if (run_start && r_loaded) w_state_nxt = c_st_clear;
                else if (step_req && r_loaded)  w_state_nxt = c_st_step;
            end
            c_st_load: begin
                // An abort wins over a word offered in the same cycle.
                if (halt_req) begin
                    w_state_nxt = c_st_idle;
                end else if (in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    if (r_wptr == c_last_addr) w_state_nxt = c_st_idle;
                end
            end
            c_st_clear: w_state_nxt = c_st_run;
            c_st_run: begin
                if (halt_req)
                    w_cause = 2'd1;
                else if ((max_cycles != '0) && (w_count_inc == {1'b0, max_cycles}))
                    w_cause = 2'd2;
                else if ((r_cycle_count >= CYC_W'(2)) && (cpu_pc == r_last_pc))
                    w_cause = 2'd3;
                if (w_cause != 2'd0) w_state_nxt = c_st_done;
            end
            c_st_step: w_state_nxt = c_st_idle;
            c_st_done: begin
                if (load_start)     w_state_nxt = c_st_load;
                else if (run_start) w_state_nxt = c_st_clear;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Control outputs are flops decoded from the next state, so pc_enable
    // never has a combinational path from any input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_wptr        <= '0;
            r_last_pc     <= '0;
            r_in_ready    <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_waddr   <= '0;
            r_ram_wdata   <= '0;
            r_cpu_reset   <= 1'b0;
            r_pc_enable   <= 1'b0;
            r_busy        <= 1'b0;
            r_loaded      <= 1'b0;
            r_done        <= 1'b0;
            r_stop_cause  <= 2'd0;
            r_cycle_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == c_st_load);
            r_cpu_reset <= (w_state_nxt == c_st_clear);
            r_pc_enable <= (w_state_nxt == c_st_run) || (w_state_nxt == c_st_step);
            r_busy      <= (w_state_nxt == c_st_load) || (w_state_nxt == c_st_clear) ||
                           (w_state_nxt == c_st_run)  || (w_state_nxt == c_st_step);
            r_ram_we    <= w_accept;

            if (w_accept) begin
                r_ram_waddr <= r_wptr;
                r_ram_wdata <= in_data;
                r_wptr      <= r_wptr + ADDR_W'(1);
            end

            if ((r_state == c_st_run) || (r_state == c_st_step)) begin
                if (r_cycle_count != '1) r_cycle_count <= w_count_inc[CYC_W-1:0];
            end

            if (r_state == c_st_run) r_last_pc <= cpu_pc;

            // A new image also invalidates the previous run statistics.
            if ((r_state != c_st_load) && (w_state_nxt == c_st_load)) begin
                r_loaded      <= 1'b0;
                r_done        <= 1'b0;
                r_stop_cause  <= 2'd0;
                r_wptr        <= '0;
                r_cycle_count <= '0;
            end

            if ((r_state == c_st_load) && (w_state_nxt == c_st_idle)) r_loaded <= w_accept;

            if (w_state_nxt == c_st_clear) begin
                r_cycle_count <= '0;
                r_stop_cause  <= 2'd0;
                r_done        <= 1'b0;
            end

            if ((r_state == c_st_run) && (w_state_nxt == c_st_done)) begin
                r_done       <= 1'b1;
                r_stop_cause <= w_cause;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign ram_we      = r_ram_we;
    assign ram_waddr   = r_ram_waddr;
    assign ram_wdata   = r_ram_wdata;
    assign cpu_reset   = r_cpu_reset;
    assign pc_enable   = r_pc_enable;
    assign busy        = r_busy;
    assign loaded      = r_loaded;
    assign done        = r_done;
    assign stop_cause  = r_stop_cause;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_controller
// Brief    : Scoreboard bench for cpu_run_controller with a tiny CPU/RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_controller;

    localparam int DATA_W = 11;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int CYC_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              run_start = 1'b0;
    logic              step_req = 1'b0;
    logic              halt_req = 1'b0;
    logic [CYC_W-1:0]  max_cycles = '0;
    logic [ADDR_W-1:0] cpu_pc;
    logic              in_ready, ram_we, cpu_reset, pc_enable, busy, loaded, done;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [1:0]        stop_cause;
    logic [CYC_W-1:0]  cycle_count;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .run_start(run_start),
        .step_req(step_req), .halt_req(halt_req), .max_cycles(max_cycles),
        .cpu_pc(cpu_pc), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .cpu_reset(cpu_reset), .pc_enable(pc_enable),
        .busy(busy), .loaded(loaded), .done(done), .stop_cause(stop_cause),
        .cycle_count(cycle_count)
    );

    // CPU model: words with top bits 3'b111 jump to word[2:0], all else fall through.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] pc_m;
    always_ff @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          pc_m <= '0;
        else if (cpu_reset) pc_m <= '0;
        else if (pc_enable) pc_m <= (mem[pc_m][10:8] == 3'b111) ? mem[pc_m][2:0] : pc_m + 3'd1;
    end
    assign cpu_pc = pc_m;

    typedef struct packed { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_t;
    typedef struct packed { logic [1:0] cause; logic [CYC_W-1:0] cnt; logic [ADDR_W-1:0] pc; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int checks = 0;
    int errors = 0;
    int pe_cnt = 0;
    int cr_cnt = 0;
    logic prev_done = 1'b0;
    logic [DATA_W-1:0] img [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes / stop events whenever the DUT presents them.
    always @(negedge clk) begin
        if (ram_we) begin
            chk("write_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                wr_t e;
                e = wq.pop_front();
                chk("ram_waddr", 32'(ram_waddr), 32'(e.a));
                chk("ram_wdata", 32'(ram_wdata), 32'(e.d));
            end
        end
        if (done && !prev_done) begin
            chk("done_expected", 32'(dq.size() > 0), 1);
            if (dq.size() > 0) begin
                dn_t e;
                e = dq.pop_front();
                chk("stop_cause", 32'(stop_cause), 32'(e.cause));
                chk("cycle_count_at_done", 32'(cycle_count), 32'(e.cnt));
                chk("cpu_pc_at_done", 32'(cpu_pc), 32'(e.pc));
                chk("pc_enable_at_done", 32'(pc_enable), 0);
            end
        end
        prev_done = done;
        if (pc_enable) pe_cnt++;
        if (cpu_reset) cr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n, input bit gap);
        logic rdy;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = img[i];
            rdy = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                rdy = in_ready;
                tick();
                if (rdy) break;
            end
            if (!rdy) begin
                chk("in_ready_timeout", 32'(rdy), 1);
                in_valid = 1'b0;
                return;
            end
            wq.push_back('{a: ADDR_W'(i), d: img[i]});
            in_valid = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic run(input logic [CYC_W-1:0] m);
        max_cycles = m;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (done) break;
        end
        #1;
        chk("done_reached", 32'(done), 1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({in_ready, ram_we, ram_waddr, ram_wdata, cpu_reset, pc_enable,
                    busy, loaded, done, stop_cause, cycle_count});
    endfunction

    initial begin
        int pe0, cr0;
        #1;
        chk("reset_outputs", all_outs(), 0);
        tick();
        reset = 1'b0;
        tick();

        // 1: load 0x001..0x008 with a bubble after every word
        for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(i + 1);
        load_words(DEPTH, 1'b1);
        chk("loaded_after_load", 32'(loaded), 1);
        chk("in_ready_after_last", 32'(in_ready), 0);
        chk("busy_after_load", 32'(busy), 0);

        // 2: self-jump at address 5 after five NOPs
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
        img[5] = 11'h705;
        load_words(DEPTH, 1'b0);
        tick();
        pe0 = pe_cnt; cr0 = cr_cnt;
        dq.push_back('{cause: 2'd3, cnt: 8'd7, pc: 3'd5});
        run(8'd0);
        wait_done(40);
        chk("selfjump_pc_enable_cycles", 32'(pe_cnt - pe0), 7);
        chk("selfjump_cpu_reset_cycles", 32'(cr_cnt - cr0), 1);
        tick();
        chk("selfjump_pc_holds", 32'(cpu_pc), 5);

        // 3: budget stop after exactly three instructions
        for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(i + 1);
        load_words(DEPTH, 1'b0);
        tick();
        pe0 = pe_cnt;
        dq.push_back('{cause: 2'd2, cnt: 8'd3, pc: 3'd3});
        run(8'd3);
        wait_done(40);
        chk("budget_pc_enable_cycles", 32'(pe_cnt - pe0), 3);

        // 4: halt on the second RUN cycle, then two single steps after reload
        pe0 = pe_cnt;
        dq.push_back('{cause: 2'd1, cnt: 8'd2, pc: 3'd2});
        run(8'd0);
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        wait_done(10);
        chk("halt_pc_enable_cycles", 32'(pe_cnt - pe0), 2);
        load_words(DEPTH, 1'b0);
        tick();
        pe0 = pe_cnt; cr0 = cr_cnt;
        for (int s = 0; s < 2; s++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            tick();
        end
        tick();
        chk("step_pc_enable_cycles", 32'(pe_cnt - pe0), 2);
        chk("step_cpu_reset_cycles", 32'(cr_cnt - cr0), 0);
        chk("step_cycle_count", 32'(cycle_count), 2);
        chk("step_done", 32'(done), 0);
        chk("step_cpu_pc", 32'(cpu_pc), 4);

        // 5: abort a load after three words; run is then refused
        load_words(3, 1'b1);
        in_valid = 1'b1;
        in_data  = 11'h7ff;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("abort_loaded", 32'(loaded), 0);
        chk("abort_busy", 32'(busy), 0);
        pe0 = pe_cnt; cr0 = cr_cnt;
        run(8'd0);
        repeat (4) tick();
        chk("abort_run_pc_enable", 32'(pe_cnt - pe0), 0);
        chk("abort_run_cpu_reset", 32'(cr_cnt - cr0), 0);

        // 6: asynchronous reset in the middle of a run
        load_words(DEPTH, 1'b0);
        tick();
        run(8'd0);
        tick();
        tick();
        chk("run_active_before_reset", 32'(pc_enable), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        tick();
        reset = 1'b0;
        tick();
        pe0 = pe_cnt; cr0 = cr_cnt;
        run(8'd0);
        repeat (4) tick();
        chk("post_reset_run_pc_enable", 32'(pe_cnt - pe0), 0);
        chk("post_reset_run_cpu_reset", 32'(cr_cnt - cr0), 0);

        chk("write_queue_drained", 32'(wq.size()), 0);
        chk("done_queue_drained", 32'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequencer for the 5-bit CPU datapath (PC, 8x11-bit program RAM, register file).
- Streams a program image into RAM over a valid/ready handshake, then clears the CPU and gates PC_Enable to run, single-step or stop it.
- Stops on an external halt, on a cycle budget, or on a detected self-jump.
- Sits between the testbench/host and the CPU's RAM_Write_* / reset / PC_Enable inputs.

Parameters:
DATA_W, 11, program word width (RAM_Write_Data width)
ADDR_W, 3, RAM address width
DEPTH, 8, words per load session (must equal 2**ADDR_W)
CYC_W, 8, cycle counter / budget width

Ports:
clk  in  1  system clock, same net as CPU clk
reset  in  1  asynchronous, active-high reset
load_start  in  1  begin load session (level, sampled per cycle)
in_valid  in  1  program word valid
in_data  in  DATA_W  program word
in_ready  out  1  controller accepts word this cycle
run_start  in  1  clear CPU and run from PC 0
step_req  in  1  execute exactly one instruction
halt_req  in  1  stop run / abort load
max_cycles  in  CYC_W  run budget; 0 = unlimited
cpu_pc  in  ADDR_W  CPU PC output, for self-jump detection
ram_we  out  1  to RAM_Write_Enable
ram_waddr  out  ADDR_W  to RAM_Write_Address
ram_wdata  out  DATA_W  to RAM_Write_Data
cpu_reset  out  1  to CPU reset (OR'd with system reset at top level)
pc_enable  out  1  to PC_Enable
busy  out  1  state is LOAD, CLEAR, RUN or STEP
loaded  out  1  full image present in RAM
done  out  1  run finished
stop_cause  out  2  0 none, 1 halt_req, 2 budget, 3 self-jump
cycle_count  out  CYC_W  enabled CPU cycles since last CLEAR

Behaviour:
- **Registered outputs.** All outputs are registered. On reset (async): state IDLE, and all outputs are 0, including wptr and last_pc.
- **States.** IDLE, LOAD, CLEAR, RUN, STEP, DONE.
- **IDLE priority.** load_start > run_start > step_req.
  - load_start -> LOAD; clears loaded, done, stop_cause; wptr=0.
  - run_start with loaded=1 -> CLEAR. With loaded=0 it is ignored.
  - step_req with loaded=1 -> STEP. With loaded=0 it is ignored.
- **LOAD.**
  - in_ready=1.
  - Each cycle with in_valid&in_ready: next cycle ram_we=1, ram_waddr=wptr, ram_wdata=in_data (1-cycle latency); then wptr++.
  - Gaps in in_valid produce ram_we=0 and hold wptr.
  - On accepting word DEPTH-1: next state IDLE, loaded=1, in_ready=0.
  - halt_req in LOAD (priority over a simultaneous word): abort to IDLE, loaded=0, no write for that cycle. Partial words remain in RAM.
  - load_start while in LOAD is ignored.
- **CLEAR.**
  - cpu_reset=1 for exactly one cycle, pc_enable=0, cycle_count=0, stop_cause=0, done=0.
  - Next state RUN.
- **RUN.**
  - pc_enable=1; cycle_count++ per cycle (saturates at all-ones); last_pc<=cpu_pc each cycle.
  - Stop checks, evaluated each cycle in priority order; the first match -> DONE with pc_enable=0 from the next cycle:
    1. halt_req -> cause 1.
    2. max_cycles!=0 and cycle_count+1==max_cycles -> cause 2. The CPU executes exactly max_cycles instructions.
    3. At least 2 RUN cycles elapsed and cpu_pc==last_pc -> cause 3.
  - load_start and run_start are ignored while in RUN.
- **STEP.**
  - pc_enable=1 for exactly one cycle, cycle_count++ (no cpu_reset).
  - Returns to IDLE; a step never sets done.
  - step_req held high produces one step per IDLE->STEP round trip, i.e. every 2 cycles.
- **DONE.**
  - done=1, pc_enable=0; done and stop_cause are held.
  - load_start -> LOAD. run_start -> CLEAR (re-run). step_req is ignored.
- **Reset mid-operation.** Any state returns to IDLE immediately; RAM contents are untouched but loaded=0.
- **Glitch rule.** pc_enable is driven only from state-register decode, with no combinational input path, so the CPU's clk&PC_Enable gate sees no glitches.

Test Plan:
1. **Load with back-pressure.** load_start, then 8 words 0x001..0x008 with in_valid low every other cycle -> ram_we pulses at addresses 0..7 with matching data, 1 cycle after each accept; loaded=1; in_ready=0 after the 8th word.
2. **Self-jump stop.** Image with JMP-to-self at address 5, preceded by 5 NOP-class words; run_start, max_cycles=0 -> cpu_reset 1 cycle, pc_enable high; done=1, stop_cause=3, PC holds 5, pc_enable=0.
3. **Budget stop.** Straight-line image, max_cycles=3, run_start -> exactly 3 pc_enable cycles, cycle_count=3, stop_cause=2, cpu_pc=3.
4. **Halt and step.** halt_req asserted on the 2nd RUN cycle -> stop_cause=1, done=1. After reload, step_req pulsed twice from IDLE -> two single-cycle pc_enable pulses, cycle_count=2, done=0.
5. **Load abort.** halt_req after 3 accepted words -> IDLE, loaded=0; subsequent run_start ignored (no cpu_reset, no pc_enable).
6. **Async reset mid-run.** reset asserted asynchronously during RUN -> all outputs 0 without waiting for a clk edge; state IDLE; run_start then ignored until a full reload.
